// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: shifts a latched parallel pattern out MSB-first,
// repeating the frame a programmable number of times with a fixed idle gap.
module serial_pattern_tx #(
  parameter int WIDTH   = 8,
  parameter int GAP_LEN = 2,
  parameter int CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] pattern,
  input  logic [3:0]       repeat_cnt,
  output logic             dout,
  output logic             dout_valid,
  output logic             frame_end,
  output logic             done,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);
  // GAP is never entered when GAP_LEN is 0, so the value then is irrelevant.
  localparam logic [CNT_W-1:0] GAP_LAST = (GAP_LEN > 0) ? CNT_W'(GAP_LEN - 1) : '0;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [3:0]       frames_q, frames_d;
  logic [CNT_W-1:0] bitcnt_q, bitcnt_d;
  logic [CNT_W-1:0] gapcnt_q, gapcnt_d;
  logic             dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             frame_end_q, frame_end_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    frames_d    = frames_q;
    bitcnt_d    = bitcnt_q;
    gapcnt_d    = gapcnt_q;
    busy_d      = busy_q;
    dout_d      = 1'b0;
    valid_d     = 1'b0;
    frame_end_d = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        // abort beats a simultaneous start
        if (start && !abort) begin
          shift_d  = pattern;
          hold_d   = pattern;
          frames_d = (repeat_cnt == 4'd0) ? 4'd1 : repeat_cnt;
          bitcnt_d = '0;
          busy_d   = 1'b1;
          state_d  = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (abort) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          dout_d   = shift_q[WIDTH-1];
          shift_d  = shift_q << 1;
          valid_d  = 1'b1;
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q == BIT_LAST) begin
            frame_end_d = 1'b1;
            frames_d    = frames_q - 1'b1;
            if (frames_q == 4'd1) begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = S_IDLE;
            end else if (GAP_LEN > 0) begin
              gapcnt_d = '0;
              state_d  = S_GAP;
            end else begin
              shift_d  = hold_q;
              bitcnt_d = '0;
            end
          end
        end
      end

      S_GAP: begin
        if (abort) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          gapcnt_d = gapcnt_q + 1'b1;
          if (gapcnt_q == GAP_LAST) begin
            shift_d  = hold_q;
            bitcnt_d = '0;
            state_d  = S_SHIFT;
          end
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      hold_q      <= '0;
      frames_q    <= '0;
      bitcnt_q    <= '0;
      gapcnt_q    <= '0;
      dout_q      <= 1'b0;
      valid_q     <= 1'b0;
      frame_end_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      frames_q    <= frames_d;
      bitcnt_q    <= bitcnt_d;
      gapcnt_q    <= gapcnt_d;
      dout_q      <= dout_d;
      valid_q     <= valid_d;
      frame_end_q <= frame_end_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign frame_end  = frame_end_q;
  assign done       = done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: one instance with a 2-cycle gap and one with
// back-to-back frames, fed the same stimulus and checked by a bit scoreboard.
module tb_serial_pattern_tx;

  localparam int W   = 8;
  localparam int GAP = 2;
  localparam logic [3:0] GAP_DC = 4'hF;

  logic         clk;
  logic         rst;
  logic         start;
  logic         abort;
  logic [W-1:0] pattern;
  logic [3:0]   repeat_cnt;
  logic         dout, dout_valid, frame_end, done, busy;
  logic         dout0, dout_valid0, frame_end0, done0, busy0;

  int tests = 0;
  int fails = 0;

  // item = {gap before this bit (F = unchecked), done, frame_end, dout}
  logic [6:0] exp_q[$];
  logic [6:0] exp0_q[$];
  int         idle_run[2];

  serial_pattern_tx #(.WIDTH(W), .GAP_LEN(GAP), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .pattern(pattern),
    .repeat_cnt(repeat_cnt), .dout(dout), .dout_valid(dout_valid),
    .frame_end(frame_end), .done(done), .busy(busy)
  );

  serial_pattern_tx #(.WIDTH(W), .GAP_LEN(0), .CNT_W(4)) dut0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .pattern(pattern),
    .repeat_cnt(repeat_cnt), .dout(dout0), .dout_valid(dout_valid0),
    .frame_end(frame_end0), .done(done0), .busy(busy0)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // reference model: the frame sequence as a flat list of expected bits
  task automatic push_model(input logic [W-1:0] pat, input logic [3:0] rpt);
    int n;
    logic [3:0] g, g0;
    n = (rpt == 4'd0) ? 1 : int'(rpt);
    for (int f = 0; f < n; f++) begin
      for (int i = 0; i < W; i++) begin
        logic d, fe, dn;
        d  = pat[W-1-i];
        fe = (i == W - 1);
        dn = fe && (f == n - 1);
        if (i != 0) begin
          g = 4'd0; g0 = 4'd0;
        end else if (f == 0) begin
          g = GAP_DC; g0 = GAP_DC;
        end else begin
          g = 4'(GAP); g0 = 4'd0;
        end
        exp_q.push_back({g, dn, fe, d});
        exp0_q.push_back({g0, dn, fe, d});
      end
    end
  endtask

  // monitor
  task automatic mon(input int id, input logic v, input logic d,
                     input logic fe, input logic dn);
    logic [6:0] it;
    int         qs;
    qs = (id == 0) ? exp_q.size() : exp0_q.size();
    if (v) begin
      tests++;
      if (qs == 0) begin
        fails++;
        $display("FAIL unexpected_bit dut%0d: got bit %0b with nothing expected", id, d);
      end else begin
        if (id == 0) it = exp_q.pop_front();
        else         it = exp0_q.pop_front();
        if ({dn, fe, d} !== it[2:0]) begin
          fails++;
          $display("FAIL bit dut%0d: got done/fe/dout=%03b, expected %03b",
                   id, {dn, fe, d}, it[2:0]);
        end
        if (it[6:3] != GAP_DC) begin
          tests++;
          if (idle_run[id] != int'(it[6:3])) begin
            fails++;
            $display("FAIL gap dut%0d: got %0d idle cycles, expected %0d",
                     id, idle_run[id], it[6:3]);
          end
        end
      end
      idle_run[id] = 0;
    end else begin
      idle_run[id]++;
      if (fe || dn) begin
        tests++;
        fails++;
        $display("FAIL pulse_no_valid dut%0d: got fe=%0b done=%0b, expected 0", id, fe, dn);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0, dout_valid, dout, frame_end, done);
      mon(1, dout_valid0, dout0, frame_end0, done0);
    end
  end

  task automatic check_quiet(input string name);
    check({name, "_dut"},  int'({dout, dout_valid, frame_end, done, busy}), 0);
    check({name, "_dut0"}, int'({dout0, dout_valid0, frame_end0, done0, busy0}), 0);
  endtask

  // driver: mode 0 = complete run, 1 = abort, 2 = reset, both after cut_at bits
  task automatic run_tx(input logic [W-1:0] pat, input logic [3:0] rpt,
                        input bit poke, input int mode, input int cut_at);
    int n, cyc, span, span0;
    n = (rpt == 4'd0) ? 1 : int'(rpt);
    push_model(pat, rpt);
    @(negedge clk);
    pattern    = pat;
    repeat_cnt = rpt;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("accept_busy", int'({busy, busy0}), 3);
    check("accept_novalid", int'({dout_valid, dout_valid0}), 0);
    span  = int'(busy);
    span0 = int'(busy0);
    cyc   = 0;
    while ((busy || busy0) && cyc < 400) begin
      @(negedge clk);
      cyc++;
      span  += int'(busy);
      span0 += int'(busy0);
      if (cyc == 1) check("first_bit_valid", int'({dout_valid, dout_valid0}), 3);
      if (poke && cyc == 3) begin
        pattern    = ~pat;
        repeat_cnt = 4'hF;
        start      = 1'b1;
      end
      if (poke && cyc == 4) start = 1'b0;
      if (mode != 0 && cyc == cut_at) begin
        if (mode == 1) abort = 1'b1;
        else           rst   = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        exp0_q.delete();
        abort = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        check_quiet(mode == 1 ? "after_abort" : "after_rst");
        break;
      end
    end
    if (cyc >= 400) begin
      tests++;
      fails++;
      $display("FAIL timeout: busy still high after %0d cycles, expected low", cyc);
    end else if (mode == 0) begin
      check("busy_span_gap", span, n * W + (n - 1) * GAP);
      check("busy_span_nogap", span0, n * W);
    end
    @(negedge clk);
    check("idle_after_run", int'({dout_valid, dout_valid0, busy, busy0}), 0);
    check("queue_drained", exp_q.size() + exp0_q.size(), 0);
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b1;
    abort      = 1'b0;
    pattern    = 8'hFF;
    repeat_cnt = 4'd1;
    idle_run[0] = 0;
    idle_run[1] = 0;
    repeat (3) begin
      @(negedge clk);
      check_quiet("reset");
    end
    rst   = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_quiet("post_reset_idle");

    run_tx(8'hB4, 4'd1, 1'b0, 0, 0);
    run_tx(8'hA5, 4'd3, 1'b0, 0, 0);
    run_tx(8'hF0, 4'd1, 1'b1, 0, 0);
    run_tx(8'h3C, 4'd2, 1'b0, 1, 4);
    run_tx(8'h96, 4'd1, 1'b0, 0, 0);
    run_tx(8'h5A, 4'd2, 1'b0, 2, 3);
    run_tx(8'hC3, 4'd0, 1'b0, 0, 0);

    // abort in IDLE, alone and together with start
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    check_quiet("abort_idle");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check_quiet("abort_with_start");
    repeat (2) @(negedge clk);
    check_quiet("abort_with_start_later");

    for (int t = 0; t < 12; t++) begin
      run_tx(W'($urandom), 4'($urandom_range(0, 4)), ($urandom_range(0, 3) == 0),
             0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
